// File: rtl/spi_aes_slave_endpoint.sv
// SPI target endpoint for one AES core: shifts in a data block and key MSB first,
// starts the core, waits for its result and shifts the 128-bit result back out on sdo.
module spi_aes_slave_endpoint #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 sdi,
    output logic                 sdo,
    output logic [127:0]         core_data,
    output logic [Nk*32-1:0]     core_key,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic [127:0]         core_result,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int N  = 128 + Nk * 32;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_RX = CW'(N - 1);
    localparam logic [CW-1:0] LAST_TX = CW'(127);

    // Nr only documents which core this endpoint is paired with.
    if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_cfg
        $error("spi_aes_slave_endpoint: unsupported Nk/Nr combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_START,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t          state;
    logic            armed;
    logic [N-2:0]    rx;
    logic [127:0]    tx;
    logic [CW-1:0]   cnt;

    assign busy = (state != S_IDLE);

    // NOTE: every register here, including the wide rx/tx shifters, is reset;
    // they are plain flops, not a memory array, so clearing them costs nothing extra.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every branch
        // below reads the values from before this edge.
        if (rst) begin
            state      <= S_IDLE;
            armed      <= 1'b1;
            rx         <= '0;
            tx         <= '0;
            cnt        <= '0;
            sdo        <= 1'b0;
            core_start <= 1'b0;
            frame_done <= 1'b0;
            core_data  <= '0;
            core_key   <= '0;
        end else if (cs_n && state inside {S_RECV, S_START, S_WAIT, S_SEND}) begin
            // Master dropped the frame: discard partial data, keep the last loaded block.
            state      <= S_IDLE;
            rx         <= '0;
            tx         <= '0;
            cnt        <= '0;
            sdo        <= 1'b0;
            core_start <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cs_n) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        rx    <= {{(N-2){1'b0}}, sdi};
                        cnt   <= CW'(1);
                        state <= S_RECV;
                    end
                end

                S_RECV: begin
                    if (cnt == LAST_RX) begin
                        // The last bit goes straight into the outputs, never into rx.
                        {core_data, core_key} <= {rx, sdi};
                        core_start            <= 1'b1;
                        state                 <= S_START;
                    end else begin
                        rx  <= {rx[N-3:0], sdi};
                        cnt <= cnt + 1'b1;
                    end
                end

                S_START: begin
                    core_start <= 1'b0;
                    state      <= S_WAIT;
                end

                S_WAIT: begin
                    if (core_done) begin
                        // First result bit is driven now; tx holds the bits still to go.
                        sdo   <= core_result[127];
                        tx    <= {core_result[126:0], 1'b0};
                        cnt   <= '0;
                        state <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (cnt == LAST_TX) begin
                        sdo        <= 1'b0;
                        frame_done <= 1'b1;
                        armed      <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        sdo <= tx[127];
                        tx  <= {tx[126:0], 1'b0};
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    frame_done <= 1'b0;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_aes_slave_endpoint.sv
// Self-checking bench for spi_aes_slave_endpoint: Nk=4 and Nk=8 instances, a table of
// frames plus hand-written abort, reset and re-arm sequences.
module tb_spi_aes_slave_endpoint;

    logic         clk = 1'b0;
    logic         rst;
    logic         cs_n4;
    logic         cs_n8;
    logic         sdi;
    logic         core_done;
    logic [127:0] core_result;

    logic         sdo4, start4, busy4, fd4;
    logic [127:0] data4;
    logic [127:0] key4;
    logic         sdo8, start8, busy8, fd8;
    logic [127:0] data8;
    logic [255:0] key8;

    always #5 clk = ~clk;

    spi_aes_slave_endpoint #(.Nk(4), .Nr(10)) dut4 (
        .clk(clk), .rst(rst), .cs_n(cs_n4), .sdi(sdi), .sdo(sdo4),
        .core_data(data4), .core_key(key4), .core_start(start4),
        .core_done(core_done), .core_result(core_result),
        .busy(busy4), .frame_done(fd4)
    );

    spi_aes_slave_endpoint #(.Nk(8), .Nr(14)) dut8 (
        .clk(clk), .rst(rst), .cs_n(cs_n8), .sdi(sdi), .sdo(sdo8),
        .core_data(data8), .core_key(key8), .core_start(start8),
        .core_done(core_done), .core_result(core_result),
        .busy(busy8), .frame_done(fd8)
    );

    int checks   = 0;
    int failures = 0;
    int starts   = 0;
    int fdones   = 0;
    bit sel8     = 1'b0;

    logic         m_sdo, m_start, m_busy, m_fd;
    logic [127:0] m_data;
    logic [255:0] m_key;

    always_comb begin
        m_sdo   = sel8 ? sdo8   : sdo4;
        m_start = sel8 ? start8 : start4;
        m_busy  = sel8 ? busy8  : busy4;
        m_fd    = sel8 ? fd8    : fd4;
        m_data  = sel8 ? data8  : data4;
        m_key   = sel8 ? key8   : {128'b0, key4};
    end

    // Pulse counters, updated at the edge that ends each pulse.
    always @(posedge clk) begin
        starts <= starts + int'(start4) + int'(start8);
        fdones <= fdones + int'(fd4) + int'(fd8);
    end

    typedef struct {
        logic [127:0] data;
        logic [255:0] key;
        logic [127:0] result;
        int           delay;
        bit           level;
        bit           early;
    } vec_t;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_cs(input logic v);
        if (sel8) cs_n8 = v;
        else      cs_n4 = v;
    endtask

    // One complete frame on the selected instance. rst_bit >= 0 pulses rst while that
    // result bit is on sdo and checks the reset state instead of frame completion.
    task automatic run_frame(input string tag, input vec_t v, input int rst_bit);
        int           nbits;
        int           kbits;
        int           s0;
        int           f0;
        int           bad;
        bit           q[$];
        logic [127:0] got;
        nbits = sel8 ? 384 : 256;
        kbits = nbits - 128;
        s0    = starts;
        f0    = fdones;
        bad   = 0;
        got   = '0;
        // Serial order: data MSB first, then key MSB first.
        for (int k = 0; k < 128; k++)   q.push_back(v.data[127 - k]);
        for (int j = 0; j < kbits; j++) q.push_back(v.key[kbits - 1 - j]);

        set_cs(1'b1);
        sdi = 1'b0;
        @(negedge clk);
        if (v.early) begin
            core_done   = 1'b1;
            core_result = ~v.result;
        end
        set_cs(1'b0);
        for (int k = 0; k < nbits; k++) begin
            sdi = q[k];
            @(negedge clk);
            if (k < nbits - 1 && m_start) bad++;
        end
        sdi = 1'b0;
        check({tag, " start_early"}, 384'(bad), 384'(0));
        check({tag, " start_after_last"}, 384'(m_start), 384'(1));
        check({tag, " core_data"}, 384'(m_data), 384'(v.data));
        check({tag, " core_key"}, 384'(m_key), 384'(v.key));

        bad = 0;
        for (int d = 0; d < v.delay; d++) begin
            @(negedge clk);
            if (d == 0) begin
                core_done   = 1'b0;
                core_result = v.result;
            end
            if (m_sdo || m_start || !m_busy) bad++;
        end
        check({tag, " wait_quiet"}, 384'(bad), 384'(0));

        core_done   = 1'b1;
        core_result = v.result;
        bad = 0;
        for (int b = 0; b < 128; b++) begin
            @(negedge clk);
            if (b == 0 && !v.level) core_done = 1'b0;
            got[127 - b] = m_sdo;
            if (m_fd) bad++;
            if (b == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                set_cs(1'b1);
                core_done = 1'b0;
                check({tag, " rst_sdo"}, 384'(m_sdo), 384'(0));
                check({tag, " rst_busy"}, 384'(m_busy), 384'(0));
                check({tag, " rst_core_data"}, 384'(m_data), 384'(0));
                bad = 0;
                for (int i = 0; i < 140; i++) begin
                    @(negedge clk);
                    if (m_sdo || m_busy) bad++;
                end
                check({tag, " rst_quiet"}, 384'(bad), 384'(0));
                check({tag, " rst_no_frame_done"}, 384'(fdones - f0), 384'(0));
                return;
            end
        end
        check({tag, " frame_done_early"}, 384'(bad), 384'(0));
        @(negedge clk);
        check({tag, " frame_done_pulse"}, 384'({m_fd, m_sdo, m_busy}), 384'(3'b101));
        core_done = 1'b0;
        @(negedge clk);
        check({tag, " after_done"}, 384'({m_fd, m_busy}), 384'(2'b00));
        check({tag, " sdo_stream"}, 384'(got), 384'(v.result));
        check({tag, " pulse_counts"}, 384'({starts - s0, fdones - f0}), {320'b0, 32'd1, 32'd1});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vec_t v;
        int   s0;
        int   bad;
        logic [127:0] held;

        rst = 1'b1; cs_n4 = 1'b1; cs_n8 = 1'b1; sdi = 1'b0;
        core_done = 1'b0; core_result = '0;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff,
                    256'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, 1'b0, 1'b0};
        vecs[1] = '{rnd128(), {128'b0, rnd128()}, rnd128(), 1, 1'b1, 1'b0};
        vecs[2] = '{rnd128(), {128'b0, rnd128()}, rnd128(), 3, 1'b0, 1'b1};
        vecs[3] = '{rnd128(), {128'b0, rnd128()}, rnd128(), 8, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("reset4_outputs", 384'({sdo4, start4, busy4, fd4}), 384'(0));
        check("reset4_core", 384'({data4, key4}), 384'(0));
        check("reset8_outputs", 384'({sdo8, start8, busy8, fd8, data8, key8}), 384'(0));
        rst = 1'b0;
        @(negedge clk);

        // Table of full frames on the Nk=4 instance (entries 2,3 hold core_done early).
        for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i], -1);

        // cs_n held low past DONE: nothing may start until it is seen high.
        s0 = starts; bad = 0;
        for (int i = 0; i < 300; i++) begin
            sdi = 1'($urandom());
            @(negedge clk);
            if (busy4) bad++;
        end
        check("hold_low_busy", 384'(bad), 384'(0));
        check("hold_low_no_start", 384'(starts - s0), 384'(0));
        v = '{rnd128(), {128'b0, rnd128()}, rnd128(), 4, 1'b0, 1'b0};
        run_frame("rearm", v, -1);

        // Abort after bit 100.
        held = data4; s0 = starts;
        cs_n4 = 1'b1; @(negedge clk);
        cs_n4 = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            sdi = 1'($urandom());
            @(negedge clk);
        end
        cs_n4 = 1'b1; sdi = 1'b0;
        @(negedge clk);
        check("abort_busy", 384'(busy4), 384'(0));
        repeat (20) @(negedge clk);
        check("abort_no_start", 384'(starts - s0), 384'(0));
        check("abort_keeps_data", 384'(data4), 384'(held));
        run_frame("post_abort", vecs[0], -1);

        // Reset while result bit 60 is on sdo.
        v = '{rnd128(), {128'b0, rnd128()}, rnd128(), 2, 1'b0, 1'b0};
        run_frame("rst_send", v, 60);
        run_frame("post_rst", vecs[0], -1);

        // Nk=8 instance.
        cs_n4 = 1'b1;
        sel8  = 1'b1;
        v = '{128'h00112233445566778899aabbccddeeff,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h8ea2b7ca516745bfeafc49904b496089, 5, 1'b0, 1'b0};
        run_frame("nk8_vec", v, -1);
        v = '{rnd128(), {rnd128(), rnd128()}, rnd128(), 6, 1'b1, 1'b1};
        run_frame("nk8_rand", v, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
